alu_writeback: RTL and testbench

- Downstream stage of the 8-bit ALU.
- Consumes one ALU result per handshake (result, mul_high, SREG, fsl, destination register), writes it into a 16x8 register file and updates the architectural status register.
- Supplies the ALU's A/B operands through two read ports, and the latched carry used by ADDC/SUBC.
- MULTIPLY needs two register-file writes, so the block holds off upstream for one extra cycle.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/reg_file_16x8.sv | 27 ++
 rtl/alu_writeback.sv | 89 ++++++++
 tb/tb_alu_writeback.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, flag bit indices and the per-opcode status-flag update mask.
package alu_pkg;

    localparam logic [3:0] ADD      = 4'b0000;
    localparam logic [3:0] SUB      = 4'b0001;
    localparam logic [3:0] ADDC     = 4'b0010;
    localparam logic [3:0] SUBC     = 4'b0011;
    localparam logic [3:0] AND      = 4'b0100;
    localparam logic [3:0] OR       = 4'b0101;
    localparam logic [3:0] XOR      = 4'b0110;
    localparam logic [3:0] INV      = 4'b0111;
    localparam logic [3:0] SLL      = 4'b1000;
    localparam logic [3:0] SRL      = 4'b1001;
    localparam logic [3:0] SRA      = 4'b1010;
    localparam logic [3:0] SLA      = 4'b1011;
    localparam logic [3:0] ROL      = 4'b1100;
    localparam logic [3:0] ROR      = 4'b1101;
    localparam logic [3:0] MULTIPLY = 4'b1110;
    localparam logic [3:0] COMPARE  = 4'b1111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {IDLE, WR_HI} state_t;

    // Mask bits are {V,N,C,Z}; a set bit means that flag is loaded from the ALU.
    function automatic logic [3:0] flag_mask(input logic [3:0] fsl);
        return fsl[3:2] == 2'b00 ? 4'b1111 :
               fsl[3:2] == 2'b01 ? 4'b0101 :
               fsl[3:2] == 2'b10 ? 4'b0111 :
               fsl == COMPARE    ? 4'b0001 : 4'b0101;
    endfunction

endpackage

// File: rtl/reg_file_16x8.sv
// reg_file_16x8: register file with one synchronous write port and two asynchronous read ports.
module reg_file_16x8 #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra_a,
    output logic [DATA_W-1:0] rd_a,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_b
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mem <= '{default: '0};
        else if (we) mem[wa] <= wd;

    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: writes ALU results into the register file and maintains the status register.
// Define ALU_WB_FWD_EN to forward in-flight writes to the read ports and carry_q.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [3:0]        in_fsl,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_mul_high,
    input  logic [3:0]        in_sreg,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [3:0]        sreg_q,
    output logic              carry_q,
    output logic              busy
);

    state_t            state, state_nx;
    logic              accept, we;
    logic [3:0]        mask, sreg_d;
    logic [ADDR_W-1:0] hi_addr, wa;
    logic [DATA_W-1:0] hi_data, wd, rf_a, rf_b;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == WR_HI ? IDLE : (accept && in_fsl == MULTIPLY) ? WR_HI : IDLE;

    always_comb begin
        in_ready = state == IDLE;
        busy     = state == WR_HI;
    end

    assign accept = in_valid && in_ready;
    assign mask   = flag_mask(in_fsl);
    assign sreg_d = accept ? (sreg_q & ~mask) | (in_sreg & mask) : sreg_q;
    // The single write port serves the low byte on accept and the latched high byte in WR_HI.
    assign we     = busy || (accept && in_fsl != COMPARE);
    assign wa     = busy ? hi_addr : in_rd;
    assign wd     = busy ? hi_data : in_result;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sreg_q  <= '0;
            hi_addr <= '0;
            hi_data <= '0;
        end else begin
            sreg_q <= sreg_d;
            if (accept && in_fsl == MULTIPLY) begin
                hi_addr <= in_rd + ADDR_W'(1);
                hi_data <= in_mul_high;
            end
        end

    reg_file_16x8 #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .wa   (wa),
        .wd   (wd),
        .ra_a (rd_addr_a),
        .rd_a (rf_a),
        .ra_b (rd_addr_b),
        .rd_b (rf_b)
    );

`ifdef ALU_WB_FWD_EN
    assign rd_data_a = (we && wa == rd_addr_a) ? wd : rf_a;
    assign rd_data_b = (we && wa == rd_addr_b) ? wd : rf_b;
    assign carry_q   = sreg_d[FLAG_C];
`else
    assign rd_data_a = rf_a;
    assign rd_data_b = rf_b;
    assign carry_q   = sreg_q[FLAG_C];
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: randomized scoreboard bench for alu_writeback against a register-file model.
module tb_alu_writeback;

    logic       clk = 0;
    logic       rst_n, in_valid, in_ready, carry_q, busy;
    logic [3:0] in_rd, in_fsl, in_sreg, rd_addr_a, rd_addr_b, sreg_q;
    logic [7:0] in_result, in_mul_high, rd_data_a, rd_data_b;

    logic [7:0] m_regs [16];
    logic [3:0] m_sreg;
    logic [3:0] exp_q [$];
    bit         exp_busy = 0;
    bit         pend = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    alu_writeback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_fsl     (in_fsl),
        .in_result  (in_result),
        .in_mul_high(in_mul_high),
        .in_sreg    (in_sreg),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .sreg_q     (sreg_q),
        .carry_q    (carry_q),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which of {V,N,C,Z} each opcode class loads from the ALU.
    function automatic logic [3:0] tb_mask(input logic [3:0] f);
        if (f <= 4'd3) return 4'b1111;
        if (f <= 4'd7) return 4'b0101;
        if (f <= 4'd11) return 4'b0111;
        if (f == 4'd15) return 4'b0001;
        return 4'b0101;
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_sreg = 4'h0;
        exp_q.delete();
        exp_busy = 0;
    endtask

    task automatic send(input logic [3:0] rd, input logic [3:0] f, input logic [7:0] res,
                        input logic [7:0] mh, input logic [3:0] sr, input logic [3:0] ra);
        logic [3:0] nxt, hi;
        nxt = (m_sreg & ~tb_mask(f)) | (sr & tb_mask(f));
        in_valid = 1; in_rd = rd; in_fsl = f; in_result = res; in_mul_high = mh; in_sreg = sr;
        rd_addr_a = ra;
        #1;
`ifdef ALU_WB_FWD_EN
        chk("fwd_rd_a", rd_data_a, (f != 4'hF && rd == ra) ? res : m_regs[ra]);
        chk("fwd_carry", carry_q, nxt[1]);
`else
        chk("rd_a", rd_data_a, m_regs[ra]);
        chk("carry", carry_q, m_sreg[1]);
`endif
        @(posedge clk);
        if (f != 4'hF) m_regs[rd] = res;
        m_sreg = nxt;
        exp_q.push_back(nxt);
        if (f == 4'hE) begin
            hi = 4'((int'(rd) + 1) % 16);
            exp_busy = 1;
            #1;
            // Upstream keeps in_valid high with unrelated data; it must be ignored.
            in_rd = 4'($urandom); in_fsl = 4'($urandom); in_result = 8'($urandom);
            in_mul_high = 8'($urandom); in_sreg = 4'($urandom); rd_addr_a = hi;
            #1;
`ifdef ALU_WB_FWD_EN
            chk("fwd_hi", rd_data_a, mh);
`else
            chk("hi_old", rd_data_a, m_regs[hi]);
`endif
            chk("hi_carry", carry_q, m_sreg[1]);
            @(posedge clk);
            m_regs[hi] = mh;
            exp_busy = 0;
        end
        #1 in_valid = 0;
    endtask

    task automatic readback();
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            #1;
            chk("reg_a", rd_data_a, m_regs[i]);
            chk("reg_b", rd_data_b, m_regs[15 - i]);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshake seen before an edge means a status update is due after it.
    always @(negedge clk) begin
        if (!rst_n) pend = 0;
        else begin
            chk("in_ready", in_ready, !exp_busy);
            chk("busy", busy, exp_busy);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow: accept seen with nothing expected at %0t", $time);
                end else chk("sreg", sreg_q, exp_q.pop_front());
            end
            pend = in_valid && in_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; in_valid = 0; in_rd = 0; in_fsl = 0; in_result = 0; in_mul_high = 0;
        in_sreg = 0; rd_addr_a = 0; rd_addr_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sreg", sreg_q, 0);
        readback();
        rst_n = 1;
        @(posedge clk);
        #1;

        send(4'd1, 4'h0, 8'h7F, 8'h00, 4'b1000, 4'd1);
        send(4'd2, 4'h4, 8'h00, 8'h00, 4'b0001, 4'd1);
        chk("bb_sreg", sreg_q, 4'b1001);
        send(4'd15, 4'hE, 8'hC8, 8'h00, 4'b0100, 4'd15);
        send(4'd3, 4'h1, 8'h11, 8'h00, 4'b0010, 4'd0);
        send(4'd4, 4'h6, 8'h22, 8'h00, 4'b0000, 4'd0);
        chk("carry_keep", carry_q, 1);
        send(4'd5, 4'h0, 8'hAA, 8'h00, 4'b0000, 4'd5);
        send(4'd5, 4'hF, 8'h33, 8'h00, 4'b0111, 4'd5);
        chk("cmp_sreg", sreg_q, 4'b0001);
        send(4'd6, 4'h0, 8'h55, 8'h00, 4'b0000, 4'd6);
        rd_addr_a = 4'd6;
        #1;
        chk("byp_next", rd_data_a, 8'h55);
        readback();

        // Reset during WR_HI drops the pending high-byte write.
        in_valid = 1; in_rd = 4'd3; in_fsl = 4'hE; in_result = 8'h10; in_mul_high = 8'h20;
        in_sreg = 4'b0100;
        @(posedge clk);
        m_regs[3] = 8'h10;
        m_sreg = (m_sreg & ~4'b0101) | (4'b0100 & 4'b0101);
        exp_q.push_back(m_sreg);
        exp_busy = 1;
        @(negedge clk);
        #1;
        rst_n = 0;
        in_valid = 0;
        model_reset();
        #1;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sreg", sreg_q, 0);
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd4;
        #1;
        chk("mid_rst_r3", rd_data_a, 8'h00);
        chk("mid_rst_r4", rd_data_b, 8'h00);
        @(posedge clk);
        #1;
        chk("mid_rst_r4_hold", rd_data_b, 8'h00);
        rst_n = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clk);
                #1;
            end
            send(4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
            if (i % 60 == 59) readback();
        end
        readback();
        repeat (2) @(negedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
